// File: rtl/counter_ext_pkg.sv
// Shared types and helpers for the counter wrap extender: snapshot FSM states
// and the wrap qualification rule used by the edge detector.
package counter_ext_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_t;

  localparam int LO_WIDTH_DEF = 4;
  localparam int HI_WIDTH_DEF = 12;
  localparam int WRAP_ARG_W   = 32;
  localparam logic [LO_WIDTH_DEF-1:0] LO_MAX = '1;

  // A wrap needs overflow seen on the all-ones value one cycle earlier, so a
  // clear-induced jump to zero never counts.
  function automatic logic is_wrap(input logic [WRAP_ARG_W-1:0] lo_prev,
                                   input logic                  ovf_prev,
                                   input logic [WRAP_ARG_W-1:0] lo_cur,
                                   input logic                  clr,
                                   input logic [WRAP_ARG_W-1:0] lo_max);
    return ovf_prev && (lo_prev == lo_max) && (lo_cur == '0) && !clr;
  endfunction

endpackage

// File: rtl/counter_wrap_extender_wrap_detect.sv
// Registers the previous upstream value/overflow and flags the cycle in which
// the upstream counter rolls from all-ones back to zero.
module wrap_detect
  import counter_ext_pkg::*;
#(
  parameter int LO_WIDTH = LO_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic [LO_WIDTH-1:0] count_lo_in,
  input  logic                overflow_in,
  output logic                wrap
);

  localparam logic [LO_WIDTH-1:0] LO_ALL_ONES = '1;

  logic [LO_WIDTH-1:0] lo_prev;
  logic                ovf_prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lo_prev  <= '0;
      ovf_prev <= 1'b0;
    end else begin
      lo_prev  <= count_lo_in;
      ovf_prev <= overflow_in;
    end
  end

  assign wrap = is_wrap(WRAP_ARG_W'(lo_prev), ovf_prev, WRAP_ARG_W'(count_lo_in),
                        clr, WRAP_ARG_W'(LO_ALL_ONES));

endmodule

// File: rtl/counter_wrap_extender.sv
// Extends the 4-bit upstream counter with a saturating wrap counter and serves
// coherent {hi, lo} snapshots over a valid/ready port.
module counter_wrap_extender
  import counter_ext_pkg::*;
#(
  parameter int HI_WIDTH = HI_WIDTH_DEF,
  parameter int LO_WIDTH = LO_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cnt_clear,
  input  logic [LO_WIDTH-1:0]          count_lo_in,
  input  logic                         overflow_in,
  input  logic                         snap_req,
  input  logic                         snap_ready,
  output logic                         snap_valid,
  output logic [HI_WIDTH+LO_WIDTH-1:0] snap_data,
  output logic [HI_WIDTH-1:0]          hi_count,
  output logic                         hi_sat,
  output logic                         snap_drop
);

  localparam logic [HI_WIDTH-1:0] HI_MAX = '1;

  logic                wrap;
  logic [HI_WIDTH-1:0] hi_next;
  logic                sat_next;
  snap_state_t         state_q, state_d;
  logic                capture;
  logic                drop_set;

  wrap_detect #(.LO_WIDTH(LO_WIDTH)) u_wrap_detect (
    .clk         (clk),
    .reset       (reset),
    .clr         (cnt_clear),
    .count_lo_in (count_lo_in),
    .overflow_in (overflow_in),
    .wrap        (wrap)
  );

  // Clear beats wrap; at all-ones the count holds rather than rolling over.
  always_comb begin
    hi_next  = hi_count;
    sat_next = hi_sat;
    if (cnt_clear) begin
      hi_next = '0;
    end else if (wrap) begin
      if (hi_count != HI_MAX) hi_next = hi_count + HI_WIDTH'(1);
      else                    sat_next = 1'b1;
    end
    if (hi_next == HI_MAX) sat_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_count <= '0;
      hi_sat   <= 1'b0;
    end else begin
      hi_count <= hi_next;
      hi_sat   <= sat_next;
    end
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    drop_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (snap_ready) begin
          // Completing a handshake frees the slot for a same-cycle request.
          capture = snap_req;
          state_d = snap_req ? HOLD : IDLE;
        end else if (snap_req) begin
          drop_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      snap_data <= '0;
      snap_drop <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture)  snap_data <= {hi_next, count_lo_in};
      if (drop_set) snap_drop <= 1'b1;
    end
  end

  assign snap_valid = (state_q == HOLD);

endmodule

// File: tb/tb_counter_wrap_extender.sv
// Directed bench for counter_wrap_extender: default widths plus a HI_WIDTH=2
// instance sharing the same stimulus for saturation behaviour.
module tb_counter_wrap_extender;

  logic        clk = 1'b0;
  logic        reset;
  logic        cnt_clear;
  logic [3:0]  count_lo_in;
  logic        overflow_in;
  logic        snap_req;
  logic        snap_ready;

  logic        snap_valid, hi_sat, snap_drop;
  logic [15:0] snap_data;
  logic [11:0] hi_count;

  logic        snap_valid2, hi_sat2, snap_drop2;
  logic [5:0]  snap_data2;
  logic [1:0]  hi_count2;

  int total = 0;
  int bad   = 0;
  logic [3:0] lo_ctr;

  always #5 clk = ~clk;

  counter_wrap_extender dut (
    .clk(clk), .reset(reset), .cnt_clear(cnt_clear), .count_lo_in(count_lo_in),
    .overflow_in(overflow_in), .snap_req(snap_req), .snap_ready(snap_ready),
    .snap_valid(snap_valid), .snap_data(snap_data), .hi_count(hi_count),
    .hi_sat(hi_sat), .snap_drop(snap_drop)
  );

  counter_wrap_extender #(.HI_WIDTH(2), .LO_WIDTH(4)) dut2 (
    .clk(clk), .reset(reset), .cnt_clear(cnt_clear), .count_lo_in(count_lo_in),
    .overflow_in(overflow_in), .snap_req(snap_req), .snap_ready(snap_ready),
    .snap_valid(snap_valid2), .snap_data(snap_data2), .hi_count(hi_count2),
    .hi_sat(hi_sat2), .snap_drop(snap_drop2)
  );

  // One clock: inputs held across the edge, outputs settled 1ns after it.
  task automatic drive(input logic [3:0] lo, input logic ovf, input logic clr,
                       input logic req, input logic rdy);
    count_lo_in = lo;
    overflow_in = ovf;
    cnt_clear   = clr;
    snap_req    = req;
    snap_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  // Upstream counter model: increments every cycle, overflow high at 15.
  task automatic tick(input logic req, input logic rdy, input logic clr);
    drive(lo_ctr, lo_ctr == 4'hF, clr, req, rdy);
    lo_ctr = lo_ctr + 4'd1;
  endtask

  task automatic run_lo(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset  = 1'b1;
    lo_ctr = 4'd0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", snap_valid); end
    total++; if (snap_data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h exp 0000", snap_data); end
    total++; if (hi_count !== 12'h0) begin bad++; $display("FAIL reset_hi: got %h exp 000", hi_count); end
    total++; if (hi_sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b exp 0", hi_sat); end
    total++; if (snap_drop !== 1'b0) begin bad++; $display("FAIL reset_drop: got %b exp 0", snap_drop); end
  endtask

  task automatic test_count40();
    run_lo(16);
    total++; if (hi_count !== 12'd0) begin bad++; $display("FAIL c40_pre_wrap: got %0d exp 0", hi_count); end
    run_lo(1);
    total++; if (hi_count !== 12'd1) begin bad++; $display("FAIL c40_wrap1: got %0d exp 1", hi_count); end
    run_lo(23);
    total++; if (hi_count !== 12'd2) begin bad++; $display("FAIL c40_hi: got %0d exp 2", hi_count); end
    tick(1'b1, 1'b0, 1'b0);
    total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL c40_valid: got %b exp 1", snap_valid); end
    total++; if (snap_data !== 16'h0028) begin bad++; $display("FAIL c40_data: got %h exp 0028", snap_data); end
    tick(1'b0, 1'b1, 1'b0);
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL c40_release: got %b exp 0", snap_valid); end
  endtask

  task automatic test_clear();
    // lo_ctr is 10 here; walk up to 15 then clear on the jump to 0.
    run_lo(6);
    total++; if (hi_count !== 12'd2) begin bad++; $display("FAIL clr_pre: got %0d exp 2", hi_count); end
    drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (hi_count !== 12'd0) begin bad++; $display("FAIL clr_hi: got %0d exp 0", hi_count); end
    // 15 without overflow then 0: not a wrap.
    drive(4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (hi_count !== 12'd0) begin bad++; $display("FAIL clr_noovf: got %0d exp 0", hi_count); end
    lo_ctr = 4'd1;
    run_lo(16);
    total++; if (hi_count !== 12'd1) begin bad++; $display("FAIL clr_rewrap: got %0d exp 1", hi_count); end
  endtask

  task automatic test_sat();
    do_reset();
    run_lo(33);
    total++; if (hi_count2 !== 2'd2) begin bad++; $display("FAIL sat_hi2: got %0d exp 2", hi_count2); end
    total++; if (hi_sat2 !== 1'b0) begin bad++; $display("FAIL sat_early: got %b exp 0", hi_sat2); end
    run_lo(16);
    total++; if (hi_count2 !== 2'd3) begin bad++; $display("FAIL sat_hi3: got %0d exp 3", hi_count2); end
    total++; if (hi_sat2 !== 1'b1) begin bad++; $display("FAIL sat_set: got %b exp 1", hi_sat2); end
    run_lo(32);
    total++; if (hi_count2 !== 2'd3) begin bad++; $display("FAIL sat_hold: got %0d exp 3", hi_count2); end
    total++; if (hi_count !== 12'd5) begin bad++; $display("FAIL sat_wide_hi: got %0d exp 5", hi_count); end
    tick(1'b0, 1'b0, 1'b1);
    total++; if (hi_count2 !== 2'd0) begin bad++; $display("FAIL sat_clr_hi: got %0d exp 0", hi_count2); end
    total++; if (hi_sat2 !== 1'b1) begin bad++; $display("FAIL sat_sticky: got %b exp 1", hi_sat2); end
    total++; if (hi_sat !== 1'b0) begin bad++; $display("FAIL sat_wide: got %b exp 0", hi_sat); end
  endtask

  task automatic test_backpressure();
    do_reset();
    run_lo(5);
    tick(1'b1, 1'b0, 1'b0);
    total++; if (snap_data !== 16'h0005) begin bad++; $display("FAIL bp_cap: got %h exp 0005", snap_data); end
    for (int k = 2; k <= 5; k++) begin
      tick(k == 3, 1'b0, 1'b0);
      total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c%0d: got %b exp 1", k, snap_valid); end
      total++; if (snap_data !== 16'h0005) begin bad++; $display("FAIL bp_data c%0d: got %h exp 0005", k, snap_data); end
      total++; if (snap_drop !== (k >= 3)) begin bad++; $display("FAIL bp_drop c%0d: got %b exp %b", k, snap_drop, k >= 3); end
    end
    tick(1'b0, 1'b1, 1'b0);
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got %b exp 0", snap_valid); end
    total++; if (snap_drop !== 1'b1) begin bad++; $display("FAIL bp_drop_sticky: got %b exp 1", snap_drop); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    run_lo(32);
    tick(1'b1, 1'b0, 1'b0);
    total++; if (snap_data !== 16'h0020) begin bad++; $display("FAIL sim_wrapcap: got %h exp 0020", snap_data); end
    total++; if (snap_data2 !== 6'h20) begin bad++; $display("FAIL sim_wrapcap2: got %h exp 20", snap_data2); end
    tick(1'b1, 1'b1, 1'b0);
    total++; if (snap_data !== 16'h0021) begin bad++; $display("FAIL sim_recap: got %h exp 0021", snap_data); end
    total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL sim_valid: got %b exp 1", snap_valid); end
    total++; if (snap_drop !== 1'b0) begin bad++; $display("FAIL sim_nodrop: got %b exp 0", snap_drop); end
    tick(1'b0, 1'b0, 1'b1);
    total++; if (hi_count !== 12'd0) begin bad++; $display("FAIL sim_clr_hi: got %0d exp 0", hi_count); end
    total++; if (snap_data !== 16'h0021) begin bad++; $display("FAIL sim_clr_hold: got %h exp 0021", snap_data); end
    total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL sim_clr_valid: got %b exp 1", snap_valid); end
  endtask

  task automatic test_reset_hold();
    run_lo(48);
    tick(1'b1, 1'b0, 1'b0);
    total++; if (hi_count !== 12'd3) begin bad++; $display("FAIL rh_hi: got %0d exp 3", hi_count); end
    total++; if (snap_drop !== 1'b1) begin bad++; $display("FAIL rh_drop: got %b exp 1", snap_drop); end
    total++; if (hi_sat2 !== 1'b1) begin bad++; $display("FAIL rh_sat2: got %b exp 1", hi_sat2); end
    reset = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL rh_valid: got %b exp 0", snap_valid); end
    total++; if (hi_count !== 12'd0) begin bad++; $display("FAIL rh_hi0: got %0d exp 0", hi_count); end
    total++; if (hi_sat2 !== 1'b0) begin bad++; $display("FAIL rh_sat0: got %b exp 0", hi_sat2); end
    total++; if (snap_drop !== 1'b0) begin bad++; $display("FAIL rh_drop0: got %b exp 0", snap_drop); end
    total++; if (snap_drop2 !== 1'b0) begin bad++; $display("FAIL rh_drop2: got %b exp 0", snap_drop2); end
  endtask

  task automatic test_back_to_back();
    lo_ctr = 4'd0;
    tick(1'b1, 1'b1, 1'b0);
    total++; if (snap_data !== 16'h0000) begin bad++; $display("FAIL b2b_0: got %h exp 0000", snap_data); end
    for (int k = 1; k <= 3; k++) begin
      tick(1'b1, 1'b1, 1'b0);
      total++; if (snap_data !== 16'(k)) begin bad++; $display("FAIL b2b_%0d: got %h exp %h", k, snap_data, 16'(k)); end
      total++; if (snap_valid2 !== 1'b1) begin bad++; $display("FAIL b2b_valid2 %0d: got %b exp 1", k, snap_valid2); end
    end
    total++; if (snap_drop !== 1'b0) begin bad++; $display("FAIL b2b_nodrop: got %b exp 0", snap_drop); end
  endtask

  initial begin
    reset = 1'b0; cnt_clear = 1'b0; count_lo_in = '0; overflow_in = 1'b0;
    snap_req = 1'b0; snap_ready = 1'b0; lo_ctr = '0;
    test_reset();
    test_count40();
    test_clear();
    test_sat();
    test_backpressure();
    test_simultaneous();
    test_reset_hold();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
